// File: rtl/viterbi_bus_pkg.sv
// Shared definitions for the Viterbi register-bus responder and the decoders
// that reuse its trellis encoding.
package viterbi_bus_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MSG     = 3'd1;
  localparam logic [2:0] REG_CODE_LO = 3'd2;
  localparam logic [2:0] REG_CODE_HI = 3'd3;
  localparam logic [2:0] REG_STATE   = 3'd4;
  localparam logic [2:0] REG_ID      = 3'd5;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;
  localparam int unsigned STAT_ERR_BIT   = 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} enc_state_t;

  // {s1, s0}: s1 is the most recently shifted-in message bit
  typedef logic [1:0] trellis_state_t;

endpackage

// File: rtl/viterbi_bus_resp_if.sv
// Chip-select/RD/WR register bus between viterbi_ctrl (master) and a responder.
interface viterbi_bus_resp_if;
  logic       cs;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic       rd;
  logic       wr;
  logic [7:0] rd_data;
  logic       ack;
  logic       irq;

  modport master (output cs, addr, wr_data, rd, wr, input rd_data, ack, irq);
  modport slave  (input cs, addr, wr_data, rd, wr, output rd_data, ack, irq);
endinterface

// File: rtl/viterbi_bus_resp_conv_enc_step.sv
// One trellis step of the rate-1/2 K=3 convolutional code; pure combinational
// so the decoder branch-metric logic can share it.
module conv_enc_step
  import viterbi_bus_pkg::*;
(
  input  logic           u,
  input  trellis_state_t state,
  input  logic [2:0]     g0,
  input  logic [2:0]     g1,
  output logic           c0,
  output logic           c1,
  output trellis_state_t next_state
);

  logic [2:0] window_s;

  // Window is {u, s1, s0}, matching the generator tap order
  always_comb begin
    window_s   = {u, state};
    c0         = ^(window_s & g0);
    c1         = ^(window_s & g1);
    next_state = {u, state[1]};
  end

endmodule

// File: rtl/viterbi_bus_resp.sv
// Register-bus responder holding an 8x8 register map and a convolutional
// encoder job engine (message byte in, 16 coded bits out).
module viterbi_bus_resp
  import viterbi_bus_pkg::*;
#(
  parameter logic [7:0] DEV_ID = 8'hA1,
  parameter logic [2:0] G0     = 3'b111,
  parameter logic [2:0] G1     = 3'b101
)
(
  input  logic               clk,
  input  logic               reset_all,
  viterbi_bus_resp_if.slave  bus
);

  enc_state_t     state_r, state_s;
  logic [7:0]     msg_r, msg_s;
  logic [15:0]    code_r, code_s;
  trellis_state_t trellis_r, trellis_s;
  logic [2:0]     bit_idx_r, bit_idx_s;
  logic           done_r, done_s;
  logic           err_r, err_s;
  logic [7:0]     rd_data_r, rd_data_s;
  logic           ack_r, ack_s;

  logic           wr_acc_s, rd_acc_s, conflict_s;
  logic           start_s, clr_s, msg_wr_s, busy_s;
  logic [7:0]     stat_s, reg_mux_s;
  logic           enc_c0_s, enc_c1_s;
  trellis_state_t enc_next_s;

  conv_enc_step u_step (
    .u          (msg_r[bit_idx_r]),
    .state      (trellis_r),
    .g0         (G0),
    .g1         (G1),
    .c0         (enc_c0_s),
    .c1         (enc_c1_s),
    .next_state (enc_next_s)
  );

  // Bus access qualification; simultaneous rd and wr performs neither
  always_comb begin
    wr_acc_s   = bus.cs & bus.wr & ~bus.rd;
    rd_acc_s   = bus.cs & bus.rd & ~bus.wr;
    conflict_s = bus.cs & bus.rd & bus.wr;
    busy_s     = (state_r == RUN);
    start_s    = wr_acc_s & (bus.addr == REG_CTRL) & bus.wr_data[CTRL_START_BIT];
    clr_s      = wr_acc_s & (bus.addr == REG_CTRL) & bus.wr_data[CTRL_CLR_BIT];
    msg_wr_s   = wr_acc_s & (bus.addr == REG_MSG);
  end

  // Read-data multiplexer over the register map
  always_comb begin
    stat_s                = 8'h00;
    stat_s[STAT_BUSY_BIT] = busy_s;
    stat_s[STAT_DONE_BIT] = done_r;
    stat_s[STAT_ERR_BIT]  = err_r;
    case (bus.addr)
      REG_CTRL:    reg_mux_s = stat_s;
      REG_MSG:     reg_mux_s = msg_r;
      REG_CODE_LO: reg_mux_s = code_r[7:0];
      REG_CODE_HI: reg_mux_s = code_r[15:8];
      REG_STATE:   reg_mux_s = {6'b000000, trellis_r};
      REG_ID:      reg_mux_s = DEV_ID;
      default:     reg_mux_s = 8'h00;
    endcase
  end

  // Next-state logic for the job FSM and register file
  always_comb begin
    state_s   = state_r;
    code_s    = code_r;
    trellis_s = trellis_r;
    bit_idx_s = bit_idx_r;
    done_s    = done_r & ~clr_s;
    ack_s     = wr_acc_s | rd_acc_s;
    rd_data_s = rd_acc_s ? reg_mux_s : rd_data_r;
    msg_s     = (msg_wr_s & ~busy_s) ? bus.wr_data : msg_r;
    // CLR is applied before any error raised in the same access
    err_s     = (err_r & ~clr_s) | conflict_s | (busy_s & (start_s | msg_wr_s));
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s   = RUN;
          code_s    = 16'h0000;
          trellis_s = 2'b00;
          bit_idx_s = 3'd0;
          done_s    = 1'b0;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        code_s[{bit_idx_r, 1'b0}] = enc_c0_s;
        code_s[{bit_idx_r, 1'b1}] = enc_c1_s;
        trellis_s = enc_next_s;
        bit_idx_s = bit_idx_r + 3'd1;
        if (bit_idx_r == 3'd7) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        done_s  = 1'b0;
      end
    endcase
  end

  // State and register update
  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      state_r   <= IDLE;
      msg_r     <= 8'h00;
      code_r    <= 16'h0000;
      trellis_r <= 2'b00;
      bit_idx_r <= 3'd0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rd_data_r <= 8'h00;
      ack_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      msg_r     <= msg_s;
      code_r    <= code_s;
      trellis_r <= trellis_s;
      bit_idx_r <= bit_idx_s;
      done_r    <= done_s;
      err_r     <= err_s;
      rd_data_r <= rd_data_s;
      ack_r     <= ack_s;
    end
  end

  assign bus.rd_data = rd_data_r;
  assign bus.ack     = ack_r;
  assign bus.irq     = done_r;

endmodule

// File: tb/tb_viterbi_bus_resp.sv
// Directed bench for viterbi_bus_resp: hand-computed encoder results, status
// timing, error handling and reset behaviour.
module tb_viterbi_bus_resp;
  import viterbi_bus_pkg::*;

  logic clk;
  logic reset_all;
  int   checks;
  int   errors;

  viterbi_bus_resp_if bus();

  viterbi_bus_resp dut (
    .clk       (clk),
    .reset_all (reset_all),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 8'h%02h expected 8'h%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d, input logic c, input string tag);
    bus.cs = c; bus.addr = a; bus.wr_data = d; bus.wr = 1'b1; bus.rd = 1'b0;
    tick();
    bus.cs = 1'b0; bus.wr = 1'b0;
    check({tag, "_ack"}, {7'd0, bus.ack}, {7'd0, c});
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    bus.cs = 1'b1; bus.addr = a; bus.rd = 1'b1; bus.wr = 1'b0;
    tick();
    bus.cs = 1'b0; bus.rd = 1'b0;
    check({tag, "_ack"}, {7'd0, bus.ack}, 8'h01);
    check(tag, bus.rd_data, exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_all = 1'b0;
    bus.cs = 1'b0; bus.addr = 3'd0; bus.wr_data = 8'h00; bus.rd = 1'b0; bus.wr = 1'b0;
    #1 reset_all = 1'b1;
    #2;
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_ack", {7'd0, bus.ack}, 8'h00);
    check("rst_irq", {7'd0, bus.irq}, 8'h00);
    @(negedge clk) reset_all = 1'b0;

    bus_rd(REG_ID, 8'hA1, "id");
    tick();
    check("ack_pulse", {7'd0, bus.ack}, 8'h00);

    // Job 0x55: busy for 8 reads, done/irq after the 8th
    bus_wr(REG_MSG, 8'h55, 1'b1, "msg55");
    bus_rd(REG_MSG, 8'h55, "msg_rb");
    bus_wr(REG_CTRL, 8'h01, 1'b1, "start55");
    for (int k = 1; k <= 8; k++) begin
      bus_rd(REG_CTRL, 8'h01, "stat_busy");
      check("irq_run", {7'd0, bus.irq}, (k == 8) ? 8'h01 : 8'h00);
    end
    bus_rd(REG_CTRL, 8'h02, "stat_done");
    bus_rd(REG_CODE_LO, 8'h47, "lo55");
    bus_rd(REG_CODE_HI, 8'h44, "hi55");
    bus_rd(REG_STATE, 8'h01, "st55");

    // Asynchronous reset in the middle of a cycle
    #2 reset_all = 1'b1;
    #1;
    check("arst_rd_data", bus.rd_data, 8'h00);
    check("arst_irq", {7'd0, bus.irq}, 8'h00);
    @(negedge clk) reset_all = 1'b0;
    bus_rd(REG_ID, 8'hA1, "id2");
    bus_rd(REG_CODE_LO, 8'h00, "arst_lo");
    bus_rd(REG_MSG, 8'h00, "arst_msg");

    // Job 0x01, then restart without CLR
    bus_wr(REG_MSG, 8'h01, 1'b1, "msg01");
    bus_wr(REG_CTRL, 8'h01, 1'b1, "start01");
    repeat (8) tick();
    bus_rd(REG_CTRL, 8'h02, "stat01");
    bus_rd(REG_CODE_LO, 8'h37, "lo01");
    bus_rd(REG_CODE_HI, 8'h00, "hi01");
    bus_rd(REG_STATE, 8'h00, "st01");
    bus_wr(REG_CTRL, 8'h01, 1'b1, "restart");
    bus_rd(REG_CTRL, 8'h01, "restart_busy");
    repeat (7) tick();
    bus_rd(REG_CTRL, 8'h02, "restart_done");
    bus_rd(REG_CODE_LO, 8'h37, "restart_lo");

    // MSG write and START while busy are ignored and flag ERR
    bus_wr(REG_MSG, 8'h55, 1'b1, "msg55b");
    bus_wr(REG_CTRL, 8'h01, 1'b1, "start55b");
    bus_rd(REG_CTRL, 8'h01, "busy55b");
    bus_wr(REG_MSG, 8'hFF, 1'b1, "msg_busy");
    bus_wr(REG_CTRL, 8'h01, 1'b1, "start_busy");
    bus_rd(REG_CTRL, 8'h05, "stat_err_busy");
    repeat (4) tick();
    bus_rd(REG_CTRL, 8'h06, "stat_err_done");
    bus_rd(REG_CODE_LO, 8'h47, "lo55b");
    bus_rd(REG_CODE_HI, 8'h44, "hi55b");
    bus_rd(REG_MSG, 8'h55, "msg_kept");
    bus_wr(REG_CTRL, 8'h02, 1'b1, "clr");
    bus_rd(REG_CTRL, 8'h00, "stat_clr");
    bus_rd(REG_STATE, 8'h01, "st55b");

    // rd and wr together with cs=1
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = REG_MSG; bus.wr_data = 8'h12;
    tick();
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    check("conflict_ack", {7'd0, bus.ack}, 8'h00);
    check("conflict_hold", bus.rd_data, 8'h01);
    bus_rd(REG_MSG, 8'h55, "conflict_msg");
    bus_rd(REG_CTRL, 8'h04, "conflict_err");
    bus_wr(REG_CTRL, 8'h02, 1'b1, "clr2");

    // Accesses with cs=0 are ignored
    bus_wr(REG_MSG, 8'h34, 1'b0, "nocs_wr");
    bus.cs = 1'b0; bus.rd = 1'b1; bus.addr = REG_ID;
    tick();
    bus.rd = 1'b0;
    check("nocs_rd_ack", {7'd0, bus.ack}, 8'h00);
    check("nocs_rd_hold", bus.rd_data, 8'h04);
    bus_rd(REG_MSG, 8'h55, "nocs_msg");
    bus_rd(REG_CTRL, 8'h00, "nocs_stat");

    // Reset during cycle N+4 of a job, then a clean job
    bus_wr(REG_CTRL, 8'h01, 1'b1, "start_abort");
    repeat (3) tick();
    reset_all = 1'b1;
    @(negedge clk) reset_all = 1'b0;
    bus_rd(REG_CTRL, 8'h00, "abort_stat");
    bus_rd(REG_CODE_LO, 8'h00, "abort_lo");
    bus_rd(REG_CODE_HI, 8'h00, "abort_hi");
    bus_wr(REG_MSG, 8'h01, 1'b1, "msg01b");
    bus_wr(REG_CTRL, 8'h01, 1'b1, "start01b");
    repeat (8) tick();
    bus_rd(REG_CTRL, 8'h02, "post_abort_done");
    bus_rd(REG_CODE_LO, 8'h37, "post_abort_lo");

    // Read-only and unmapped registers
    bus_wr(REG_CODE_LO, 8'hFF, 1'b1, "ro_wr");
    bus_rd(REG_CODE_LO, 8'h37, "ro_lo");
    bus_wr(REG_ID, 8'h00, 1'b1, "ro_id_wr");
    bus_rd(REG_ID, 8'hA1, "ro_id");
    bus_wr(3'd6, 8'h5A, 1'b1, "r6_wr");
    bus_rd(3'd6, 8'h00, "r6");
    bus_rd(REG_CTRL, 8'h02, "ro_no_err");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_bus_resp.md
Name: viterbi_bus_resp

Overview:
- Responder end of the chip-select/RD/WR register bus that viterbi_ctrl drives as initiator.
- One instance sits behind each of vit1_cs and vit2_cs.
- Exposes an 8-entry x 8-bit register map and contains a rate-1/2, K=3 convolutional encoder job engine. The encoder produces the coded stream that the Viterbi decoders later consume.
- Host flow: write a message byte, pulse start, poll status, read back 16 coded bits.

Parameters:
- DEV_ID, 8'hA1, value returned by the read-only ID register.
- G0, 3'b111, generator polynomial for coded bit c0, as {u, s1, s0} taps.
- G1, 3'b101, generator polynomial for coded bit c1.

Ports:
- clk  in  1  rising-edge clock.
- reset_all  in  1  asynchronous, active-high reset.
- cs  in  1  chip select from the controller (vit1_cs or vit2_cs).
- addr  in  3  register address (out_addr).
- wr_data  in  8  write data (vit_data).
- rd  in  1  read strobe (out_RD), qualified by cs.
- wr  in  1  write strobe (out_WR), qualified by cs.
- rd_data  out  8  read data; feeds the controller's return path.
- ack  out  1  one-cycle pulse per accepted access.
- irq  out  1  level output, equal to status.done.

Behaviour:
- Reset (async, reset_all=1): all registers 0, encoder state 2'b00, FSM IDLE, rd_data=0, ack=0, irq=0.
- All bus transactions are sampled on a rising clk edge with cs=1. When cs=0, rd/wr are ignored and ack=0.
- Write with wr=1, rd=0 takes effect at the sampling edge; ack=1 the following cycle.
- Read with rd=1, wr=0: rd_data is registered and valid the cycle after sampling, together with ack=1. rd_data holds its value between reads.
- rd=1 and wr=1 together: neither access is performed, ack=0, ERR is set.
- Register map:
  - 0 CTRL/STAT. Write bit0=START, bit1=CLR (clears DONE and ERR). Read returns {5'b0, ERR, DONE, BUSY}.
  - 1 MSG: read/write message byte.
  - 2 CODE_LO: read-only, coded bits 7..0.
  - 3 CODE_HI: read-only, coded bits 15..8.
  - 4 STATE: read-only, {6'b0, s1, s0} final encoder state.
  - 5 ID: read-only, DEV_ID.
  - 6-7: reads return 0, writes ignored.
  - Writes to read-only registers are ignored. No error is flagged.
- FSM states IDLE -> RUN -> IDLE.
  - START accepted in IDLE at edge N: CODE_LO, CODE_HI and state cleared; bit index i=0; DONE=0; BUSY=1 from cycle N+1.
  - RUN, one message bit per cycle, LSB first. u=MSG[i], window w={u,s1,s0}. c0=^(w&G0), c1=^(w&G1). code[2i]=c0, code[2i+1]=c1. Then {s1,s0} <= {u,s1}.
  - After i=7 the FSM returns to IDLE: BUSY=0 and DONE=1 visible at cycle N+9. DONE is sticky until CLR or the next START.
- CLR and START in the same write: CLR is applied first, then START.
- START while BUSY is ignored (the job is not restarted) and sets ERR.
- MSG write while BUSY is ignored and sets ERR. The job always uses the MSG value latched at START.
- Reads during RUN are legal and return partially filled CODE registers.
- Reset during RUN aborts the job immediately; everything returns to reset values.

Decomposition:
- Package viterbi_bus_pkg holds:
  - register address localparams (REG_CTRL=0 ... REG_ID=5);
  - CTRL/STAT bit positions;
  - typedef enum logic {IDLE, RUN} enc_state_t;
  - typedef logic [1:0] trellis_state_t, shared with the decoders.
- One sub-module, conv_enc_step: purely combinational (u, state, G0, G1) -> (c0, c1, next_state). It is reused by the decoder's branch-metric logic.

Test Plan:
- Reset: assert reset_all mid-cycle -> all outputs 0 asynchronously; reading ID afterwards returns 8'hA1 with ack one cycle after rd.
- MSG=8'h55, START at edge N -> BUSY=1 during N+1..N+8, DONE=1 and irq=1 at N+9; CODE_LO=8'h47, CODE_HI=8'h44, STATE=8'h01.
- MSG=8'h01, START -> CODE_LO=8'h37, CODE_HI=8'h00, STATE=8'h00; a second START without CLR clears DONE and produces the same result.
- During RUN: write MSG=8'hFF and write START -> both ignored, ERR=1 (STAT reads 8'h05 while busy), final CODE matches the original message; CLR -> STAT=8'h00.
- rd and wr together with cs=1 -> no ack, no register change, ERR=1; rd/wr with cs=0 -> no ack, no change.
- Reset asserted at cycle N+4 of a job -> STAT=0, CODE_LO/HI=0, FSM IDLE; a new START then completes normally.
